booth_mult_sequencer: RTL and testbench

- Iterative 32×32 signed radix-4 Booth multiplier sequencer.
- Sits upstream of the team's 3-bit Booth recode decoder (`multdiv_control`):
  - each cycle it presents the current 3-bit multiplier window;
  - it consumes the decoder's `do_nothing` / `shift_multiplicand` / ALU-opcode outputs to update a 34-bit partial-product accumulator.
- Produces the low 32 bits of the product, an overflow exception and a one-cycle ready strobe after 16 iterations.
- Serves as the MULT half of the processor's mult/div unit.

---
 rtl/booth_mult_sequencer_pkg.sv | 13 +
 rtl/booth_mult_sequencer_control.sv | 13 +
 rtl/booth_mult_sequencer.sv | 92 +++++++++
 tb/tb_booth_mult_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/booth_mult_sequencer_pkg.sv
// booth_mult_sequencer_pkg: constants shared by the mult/div datapath.
package booth_mult_sequencer_pkg;
    localparam int OPERAND_W  = 32;
    localparam int ACC_W      = 34;
    localparam int MULT_STEPS = 16;
    localparam int PROD_W     = ACC_W + OPERAND_W + 1;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/booth_mult_sequencer_control.sv
// multdiv_control: radix-4 Booth recode of a 3-bit multiplier window.
module multdiv_control
    import booth_mult_sequencer_pkg::*;
(
    input  logic [2:0] window,
    output logic       do_nothing,
    output logic       shift_multiplicand,
    output logic [4:0] alu_opcode
);
    assign do_nothing         = (window == 3'b000) || (window == 3'b111);
    assign shift_multiplicand = (window == 3'b011) || (window == 3'b100);
    assign alu_opcode         = window[2] ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/booth_mult_sequencer.sv
// booth_mult_sequencer: 32x32 signed radix-4 Booth multiplier, one step per cycle,
// 16 steps per product; returns the low word plus a signed-32 overflow flag.
module booth_mult_sequencer
    import booth_mult_sequencer_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ctrl_MULT,
    input  logic [OPERAND_W-1:0] data_operandA,
    input  logic [OPERAND_W-1:0] data_operandB,
    output logic [OPERAND_W-1:0] data_result,
    output logic                 data_exception,
    output logic                 data_resultRDY,
    output logic                 busy
);
    logic [0:0]           state_q, state_d;
    logic [3:0]           count_q, count_d;
    logic [ACC_W-1:0]     m_q, m_d;
    logic [PROD_W-1:0]    p_q, p_d;
    logic [OPERAND_W-1:0] result_q, result_d;
    logic                 exc_q, exc_d;
    logic                 rdy_q, rdy_d;

    logic               do_nothing, shift_mc;
    logic [4:0]         alu_op;
    logic [ACC_W-1:0]   hi, operand, hi_next;
    logic signed [PROD_W-1:0] pre_shift;
    logic [PROD_W-1:0]  stepped;

    multdiv_control u_ctrl (
        .window             (p_q[2:0]),
        .do_nothing         (do_nothing),
        .shift_multiplicand (shift_mc),
        .alu_opcode         (alu_op)
    );

    always_comb begin
        hi        = p_q[PROD_W-1:OPERAND_W+1];
        operand   = shift_mc ? {m_q[ACC_W-2:0], 1'b0} : m_q;
        hi_next   = do_nothing ? hi : (alu_op == ALU_SUB ? hi - operand : hi + operand);
        pre_shift = {hi_next, p_q[OPERAND_W:0]};
        stepped   = pre_shift >>> 2;
        state_d   = state_q;
        count_d   = count_q;
        m_d       = m_q;
        p_d       = p_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
        if (state_q == ST_IDLE && ctrl_MULT) begin
            m_d     = {{(ACC_W-OPERAND_W){data_operandA[OPERAND_W-1]}}, data_operandA};
            p_d     = {{ACC_W{1'b0}}, data_operandB, 1'b0};
            count_d = '0;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            p_d     = stepped;
            count_d = count_q + 4'd1;
            if (count_q == 4'(MULT_STEPS-1)) begin
                state_d  = ST_IDLE;
                result_d = stepped[OPERAND_W:1];
                // Upper 34 bits must all replicate the low word's sign bit.
                exc_d    = stepped[PROD_W-1:OPERAND_W+1] != {ACC_W{stepped[OPERAND_W]}};
                rdy_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            m_q      <= '0;
            p_q      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            m_q      <= m_d;
            p_q      <= p_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q == ST_RUN);
endmodule

// File: tb/tb_booth_mult_sequencer.sv
// tb_booth_mult_sequencer: scoreboard bench; expected products come from
// native 64-bit signed multiplication.
module tb_booth_mult_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl = 1'b0;
    logic [31:0] opa = '0, opb = '0;
    logic [31:0] result;
    logic        exc, rdy, busy;

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q[$];
    logic        rdy_prev = 1'b0;

    booth_mult_sequencer dut (
        .clock          (clk),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .data_result    (result),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        longint prod;
        logic [31:0] lo;
        prod = longint'($signed(a)) * longint'($signed(b));
        lo = prod[31:0];
        return {prod != longint'($signed(lo)), lo};
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 64'(rdy), 64'(0));
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("result", 64'(result), 64'(e[31:0]));
                    check("exception", 64'(exc), 64'(e[32]));
                end
                if (rdy_prev) check("strobe_width", 64'(rdy_prev), 64'(0));
            end
            rdy_prev <= rdy;
        end else begin
            rdy_prev <= 1'b0;
        end
    end

    // Starts a multiply; optionally re-pulses ctrl at edge k+repulse with junk operands.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int repulse);
        int lat;
        lat = 0;
        ctrl = 1'b1;
        opa = a;
        opb = b;
        exp_q.push_back(model(a, b));
        @(posedge clk); #1;
        ctrl = 1'b0;
        check("busy_at_start", 64'(busy), 64'(1));
        for (int i = 1; i <= 24 && lat == 0; i++) begin
            if (i == repulse) begin
                ctrl = 1'b1;
                opa = $urandom;
                opb = $urandom;
            end
            @(posedge clk); #1;
            ctrl = 1'b0;
            if (rdy) lat = i;
            else if (i < 16) check("busy_during_run", 64'(busy), 64'(1));
        end
        check("latency", 64'(lat), 64'(16));
        check("busy_after_done", 64'(busy), 64'(0));
    endtask

    initial begin
        #2;
        check("reset_result", 64'(result), 64'(0));
        check("reset_exc", 64'(exc), 64'(0));
        check("reset_rdy", 64'(rdy), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);

        run_mult(32'd3, 32'd5, 0);
        run_mult(-32'sd7, 32'd6, 0);
        run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_mult(32'h7FFFFFFF, 32'd2, 0);
        run_mult(32'h80000000, 32'hFFFFFFFF, 0);
        run_mult(32'h00010000, 32'h00010000, 0);
        run_mult(32'h80000000, 32'd1, 0);
        run_mult(32'h80000000, 32'h80000000, 0);
        run_mult(32'h7FFFFFFF, 32'h7FFFFFFF, 0);
        run_mult(32'd0, 32'h12345678, 0);

        // Mid-run restart request must be ignored.
        run_mult(32'd1000, 32'hFFFFFFF0, 5);
        check("hold_result", 64'(result), 64'(32'hFFFFC180));

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (n % 3 == 0) a = $signed(a) >>> $urandom_range(31, 16);
            if (n % 4 == 0) b = $signed(b) >>> $urandom_range(31, 16);
            run_mult(a, b, 0);
        end

        // Asynchronous reset mid-operation clears everything with no strobe.
        @(negedge clk);
        ctrl = 1'b1; opa = 32'd9; opb = 32'd9;
        @(posedge clk); #1;
        ctrl = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_result", 64'(result), 64'(0));
        check("abort_exc", 64'(exc), 64'(0));
        check("abort_rdy", 64'(rdy), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_strobe_after_abort", 64'(rdy), 64'(0));
        run_mult(32'd3, 32'd5, 0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
